// File: rtl/hbmc_rd_sched.sv
// rtl/hbmc_rd_sched.sv - credit-gated read-burst scheduler and in-order R-channel drain
module hbmc_rd_sched #(
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int FIFO_DEPTH      = 512,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // burst requests from the AR decoder
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic [7:0]            req_len,
    input  logic [ID_WIDTH-1:0]   req_id,
    // command toward the memory controller
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [31:0]           cmd_addr,
    output logic [7:0]            cmd_len,
    // upstream first-word-fall-through FIFO
    input  logic [DATA_WIDTH-1:0] fifo_rd_dout,
    input  logic                  fifo_rd_last,
    input  logic                  fifo_rd_empty,
    output logic                  fifo_rd_ena,
    // AXI R channel
    output logic [DATA_WIDTH-1:0] m_axi_rdata,
    output logic [ID_WIDTH-1:0]   m_axi_rid,
    output logic [1:0]            m_axi_rresp,
    output logic                  m_axi_rlast,
    output logic                  m_axi_rvalid,
    input  logic                  m_axi_rready,
    // status
    output logic [9:0]            credits_used,
    output logic                  err_last
);

    localparam int QAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int QCW = QAW + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // drain FSM and beat position inside the head burst
    logic [0:0]          r_state;
    logic [7:0]          r_beat;

    // in-order descriptor queue
    logic [ID_WIDTH-1:0] r_q_id  [MAX_OUTSTANDING];
    logic [7:0]          r_q_len [MAX_OUTSTANDING];
    logic [QAW-1:0]      r_wr_ptr;
    logic [QAW-1:0]      r_rd_ptr;
    logic [QCW-1:0]      r_q_cnt;

    // credit pool, command slot, status
    logic [9:0]          r_credits;
    logic                r_cmd_valid;
    logic [31:0]         r_cmd_addr;
    logic [7:0]          r_cmd_len;
    logic                r_err_last;
    logic                r_rst_d;

    logic [10:0]         w_credit_sum;
    logic                w_credit_ok;
    logic                w_q_full;
    logic                w_cmd_free;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_burst;
    logic [ID_WIDTH-1:0] w_head_id;
    logic [7:0]          w_head_len;
    logic                w_rlast;
    logic                w_rvalid;
    logic                w_pop;
    logic                w_desc_pop;
    logic                w_mismatch;
    logic [9:0]          w_credit_next;

    // Admission: the whole burst must fit in the FIFO so the memory side never stalls.
    // The sum is one bit wider than the counter so it cannot wrap.
    assign w_credit_sum = {1'b0, r_credits} + {3'b000, req_len} + 11'd1;
    assign w_credit_ok  = (w_credit_sum <= 11'(FIFO_DEPTH));
    assign w_q_full     = (r_q_cnt == QCW'(MAX_OUTSTANDING));
    assign w_cmd_free   = !r_cmd_valid || cmd_ready;
    // r_rst_d keeps admission closed for one cycle after reset is released
    assign w_req_ready  = !rst && !r_rst_d && w_credit_ok && !w_q_full && w_cmd_free;
    assign w_accept     = req_valid && w_req_ready;

    // R channel is a combinational view of the FIFO head while a burst is active.
    // The FIFO head only changes on a pop, which keeps the R payload stable under backpressure.
    assign w_burst    = (r_state == ST_BURST) && !rst;
    assign w_head_id  = r_q_id[r_rd_ptr];
    assign w_head_len = r_q_len[r_rd_ptr];
    assign w_rlast    = w_burst && (r_beat == w_head_len);
    assign w_rvalid   = w_burst && !fifo_rd_empty;
    assign w_pop      = w_rvalid && m_axi_rready;
    assign w_desc_pop = w_pop && w_rlast;
    // the FIFO last flag is only cross-checked, the beat counter alone defines RLAST
    assign w_mismatch = w_rvalid && (fifo_rd_last != w_rlast);

    assign req_ready    = w_req_ready;
    assign cmd_valid    = r_cmd_valid;
    assign cmd_addr     = r_cmd_addr;
    assign cmd_len      = r_cmd_len;
    assign fifo_rd_ena  = w_pop;
    assign m_axi_rvalid = w_rvalid;
    assign m_axi_rdata  = w_burst ? fifo_rd_dout : '0;
    assign m_axi_rid    = w_burst ? w_head_id : '0;
    assign m_axi_rlast  = w_rlast;
    assign m_axi_rresp  = w_mismatch ? RESP_SLVERR : RESP_OKAY;
    assign credits_used = r_credits;
    assign err_last     = r_err_last;

    // net credit update: reserve the full burst on accept, release one word per pop
    always_comb begin
        w_credit_next = r_credits;
        if (w_accept) begin
            w_credit_next = w_credit_next + {2'b00, req_len} + 10'd1;
        end
        if (w_pop) begin
            w_credit_next = w_credit_next - 10'd1;
        end
    end

    // credit counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= '0;
        end else begin
            r_credits <= w_credit_next;
        end
    end

    // delayed copy of reset used to hold off admission for one extra cycle
    always_ff @(posedge clk) begin
        r_rst_d <= rst;
    end

    // command slot: load on accept, hold stable until the memory controller takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_valid <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_len   <= '0;
        end else if (w_accept) begin
            r_cmd_valid <= 1'b1;
            r_cmd_addr  <= req_addr;
            r_cmd_len   <= req_len;
        end else if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
        end
    end

    // descriptor storage, written at the tail on accept
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_q_id[r_wr_ptr]  <= req_id;
            r_q_len[r_wr_ptr] <= req_len;
        end
    end

    // descriptor queue pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_q_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + QAW'(1);
            end
            if (w_desc_pop) begin
                r_rd_ptr <= r_rd_ptr + QAW'(1);
            end
            case ({w_accept, w_desc_pop})
                2'b10:   r_q_cnt <= r_q_cnt + QCW'(1);
                2'b01:   r_q_cnt <= r_q_cnt - QCW'(1);
                default: r_q_cnt <= r_q_cnt;
            endcase
        end
    end

    // drain FSM: walk the head burst beat by beat, chain into the next descriptor without a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_beat <= '0;
                    if (r_q_cnt != '0) begin
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_pop) begin
                        if (w_rlast) begin
                            r_beat <= '0;
                            if ((r_q_cnt > QCW'(1)) || w_accept) begin
                                r_state <= ST_BURST;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_beat  <= '0;
                end
            endcase
        end
    end

    // sticky last-flag mismatch, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_last <= 1'b0;
        end else if (w_pop && w_mismatch) begin
            r_err_last <= 1'b1;
        end
    end

endmodule
